accum_cpu_param: RTL and testbench

Parametrised single-issue accumulator CPU core, the successor to the course project's fixed 8-bit accumulator datapath. It executes one 4-bit-opcode/immediate instruction per accepted cycle, presented externally on `input_ins` by the instruction memory, which is indexed combinationally by `pc`. Over the original core it adds:
- configurable data, PC and immediate widths;
- a small register file;
- a carry flag and conditional jumps;
- halt;
- an instruction-valid stall handshake.

Results appear on `accum_value`/`pc` for the self-checking bench to compare against expected {acc,pc} vectors.

---
 rtl/accum_cpu_param.sv | 147 ++++++++++++++
 tb/tb_accum_cpu_param.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/accum_cpu_param.sv
`default_nettype none
// ============================================================================
// accum_cpu_param : parametrised single-issue accumulator CPU with register
//                   file, carry flag, conditional jumps, halt and stall input.
// Revision 1.0
// ============================================================================
module accum_cpu_param #(
  parameter int DATA_W = 8,
  parameter int PC_W   = 8,
  parameter int IMM_W  = 4,
  parameter int NREG   = 4
) (
  input  logic              clk,
  input  logic              CLB,
  input  logic [IMM_W+3:0]  input_ins,
  input  logic              ins_valid,
  output logic [PC_W-1:0]   pc,
  output logic [DATA_W-1:0] accum_value,
  output logic              carry,
  output logic              halted,
  output logic              retire
);

  localparam int RIDX_W = (NREG > 1) ? $clog2(NREG) : 1;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_ADDI = 4'h2;
  localparam logic [3:0] OP_SUBI = 4'h3;
  localparam logic [3:0] OP_ANDI = 4'h4;
  localparam logic [3:0] OP_ORI  = 4'h5;
  localparam logic [3:0] OP_XORI = 4'h6;
  localparam logic [3:0] OP_SHL  = 4'h7;
  localparam logic [3:0] OP_SHR  = 4'h8;
  localparam logic [3:0] OP_JMP  = 4'h9;
  localparam logic [3:0] OP_JZ   = 4'hA;
  localparam logic [3:0] OP_JC   = 4'hB;
  localparam logic [3:0] OP_STA  = 4'hC;
  localparam logic [3:0] OP_LDA  = 4'hD;
  localparam logic [3:0] OP_ADDR = 4'hE;
  localparam logic [3:0] OP_HLT  = 4'hF;

  logic [PC_W-1:0]   pc_q, pc_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic              carry_q, carry_d;
  logic              halted_q, halted_d;
  logic              retire_q, retire_d;
  logic              rf_we;
  logic [DATA_W-1:0] regs_q [NREG];

  logic [3:0]        opcode;
  logic [IMM_W-1:0]  imm;
  logic [DATA_W-1:0] imm_ext;
  logic [PC_W-1:0]   imm_pc;
  logic [PC_W-1:0]   pc_inc;
  logic [RIDX_W-1:0] ridx;
  logic [DATA_W-1:0] rf_rd;
  logic [DATA_W:0]   sum_imm, diff_imm, sum_reg, shl_ext, shr_ext;

  assign opcode  = input_ins[IMM_W+3:IMM_W];
  assign imm     = input_ins[IMM_W-1:0];
  assign imm_ext = DATA_W'(imm);
  assign imm_pc  = PC_W'(imm);
  assign pc_inc  = pc_q + PC_W'(1);

  generate
    if (NREG > 1) begin : g_ridx_multi
      assign ridx = imm[RIDX_W-1:0];
    end else begin : g_ridx_single
      assign ridx = '0;
    end
  endgenerate

  assign rf_rd = regs_q[ridx];

  // Extra MSB carries out the add / borrow; shifts keep the last bit out in the extension bit.
  assign sum_imm  = {1'b0, acc_q} + {1'b0, imm_ext};
  assign diff_imm = {1'b0, acc_q} - {1'b0, imm_ext};
  assign sum_reg  = {1'b0, acc_q} + {1'b0, rf_rd};
  assign shl_ext  = {1'b0, acc_q} << imm;
  assign shr_ext  = {acc_q, 1'b0} >> imm;

  always_comb begin
    pc_d     = pc_q;
    acc_d    = acc_q;
    carry_d  = carry_q;
    halted_d = halted_q;
    retire_d = 1'b0;
    rf_we    = 1'b0;
    if (ins_valid && !halted_q) begin
      retire_d = 1'b1;
      pc_d     = pc_inc;
      case (opcode)
        OP_NOP:  ;
        OP_LDI:  acc_d = imm_ext;
        OP_ADDI: {carry_d, acc_d} = sum_imm;
        OP_SUBI: {carry_d, acc_d} = diff_imm;
        OP_ANDI: acc_d = acc_q & imm_ext;
        OP_ORI:  acc_d = acc_q | imm_ext;
        OP_XORI: acc_d = acc_q ^ imm_ext;
        OP_SHL: begin
          if (imm != '0) {carry_d, acc_d} = shl_ext;
        end
        OP_SHR: begin
          if (imm != '0) {acc_d, carry_d} = shr_ext;
        end
        OP_JMP:  pc_d = imm_pc;
        OP_JZ:   if (acc_q == '0) pc_d = imm_pc;
        OP_JC:   if (carry_q) pc_d = imm_pc;
        OP_STA:  rf_we = 1'b1;
        OP_LDA:  acc_d = rf_rd;
        OP_ADDR: {carry_d, acc_d} = sum_reg;
        OP_HLT: begin
          pc_d     = pc_q;
          halted_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (CLB) begin
      pc_q     <= '0;
      acc_q    <= '0;
      carry_q  <= 1'b0;
      halted_q <= 1'b0;
      retire_q <= 1'b0;
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      pc_q     <= pc_d;
      acc_q    <= acc_d;
      carry_q  <= carry_d;
      halted_q <= halted_d;
      retire_q <= retire_d;
      if (rf_we) regs_q[ridx] <= acc_q;
    end
  end

  assign pc          = pc_q;
  assign accum_value = acc_q;
  assign carry       = carry_q;
  assign halted      = halted_q;
  assign retire      = retire_q;

endmodule
`default_nettype wire

// File: tb/tb_accum_cpu_param.sv
`default_nettype none
// ============================================================================
// tb_accum_cpu_param : directed program vectors with a queue-based scoreboard.
// Revision 1.0
// ============================================================================
module tb_accum_cpu_param;

  logic       clk;
  logic       CLB;
  logic [7:0] input_ins;
  logic       ins_valid;
  logic [7:0] pc;
  logic [7:0] accum_value;
  logic       carry;
  logic       halted;
  logic       retire;

  accum_cpu_param #(
    .DATA_W(8), .PC_W(8), .IMM_W(4), .NREG(4)
  ) dut (
    .clk        (clk),
    .CLB        (CLB),
    .input_ins  (input_ins),
    .ins_valid  (ins_valid),
    .pc         (pc),
    .accum_value(accum_value),
    .carry      (carry),
    .halted     (halted),
    .retire     (retire)
  );

  typedef struct packed {
    logic [15:0] id;
    logic        ret;
    logic [7:0]  pc;
    logic [7:0]  acc;
    logic        c;
    logic        h;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   id_cnt = 0;

  always #5 clk = ~clk;

  // Drive one cycle of stimulus and queue the state expected right after the edge.
  task automatic step(input logic v, input logic rst, input logic [7:0] ins,
                      input logic e_ret, input logic [7:0] e_pc, input logic [7:0] e_acc,
                      input logic e_c, input logic e_h);
    exp_t e;
    ins_valid = v;
    CLB       = rst;
    input_ins = ins;
    @(posedge clk);
    #1;
    e.id  = 16'(id_cnt);
    e.ret = e_ret;
    e.pc  = e_pc;
    e.acc = e_acc;
    e.c   = e_c;
    e.h   = e_h;
    exp_q.push_back(e);
    id_cnt++;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({retire, pc, accum_value, carry, halted} !== {e.ret, e.pc, e.acc, e.c, e.h}) begin
          errors++;
          $display("FAIL step%0d: got ret=%b pc=%h acc=%h c=%b h=%b, want ret=%b pc=%h acc=%h c=%b h=%b",
                   e.id, retire, pc, accum_value, carry, halted, e.ret, e.pc, e.acc, e.c, e.h);
        end
      end
    end
  end

  initial begin : stim
    clk       = 1'b0;
    CLB       = 1'b1;
    ins_valid = 1'b0;
    input_ins = 8'h00;

    // Arithmetic and carry out
    step(0, 1, 8'h00, 0, 8'h00, 8'h00, 0, 0);
    step(1, 0, 8'h1F, 1, 8'h01, 8'h0F, 0, 0);
    step(1, 0, 8'h2F, 1, 8'h02, 8'h1E, 0, 0);
    for (int i = 0; i < 15; i++)
      step(1, 0, 8'h2F, 1, 8'(3 + i), 8'(30 + 15 * (i + 1)), 0, 0);
    step(1, 0, 8'h21, 1, 8'h12, 8'h00, 1, 0);

    // Borrow and conditional jumps
    step(0, 1, 8'h00, 0, 8'h00, 8'h00, 0, 0);
    step(1, 0, 8'h13, 1, 8'h01, 8'h03, 0, 0);
    step(1, 0, 8'h35, 1, 8'h02, 8'hFE, 1, 0);
    step(1, 0, 8'hBA, 1, 8'h0A, 8'hFE, 1, 0);
    step(1, 0, 8'h10, 1, 8'h0B, 8'h00, 1, 0);
    step(1, 0, 8'hA4, 1, 8'h04, 8'h00, 1, 0);
    step(1, 0, 8'h11, 1, 8'h05, 8'h01, 1, 0);
    step(1, 0, 8'hA4, 1, 8'h06, 8'h01, 1, 0);
    step(1, 0, 8'h30, 1, 8'h07, 8'h01, 0, 0);
    step(1, 0, 8'hB0, 1, 8'h08, 8'h01, 0, 0);

    // Register file
    step(0, 1, 8'h00, 0, 8'h00, 8'h00, 0, 0);
    step(1, 0, 8'h19, 1, 8'h01, 8'h09, 0, 0);
    step(1, 0, 8'hC2, 1, 8'h02, 8'h09, 0, 0);
    step(1, 0, 8'h10, 1, 8'h03, 8'h00, 0, 0);
    step(1, 0, 8'hD2, 1, 8'h04, 8'h09, 0, 0);
    step(1, 0, 8'hE2, 1, 8'h05, 8'h12, 0, 0);
    step(1, 0, 8'hD3, 1, 8'h06, 8'h00, 0, 0);

    // Shifts and logic ops
    step(0, 1, 8'h00, 0, 8'h00, 8'h00, 0, 0);
    step(1, 0, 8'h19, 1, 8'h01, 8'h09, 0, 0);
    step(1, 0, 8'h74, 1, 8'h02, 8'h90, 0, 0);
    step(1, 0, 8'h71, 1, 8'h03, 8'h20, 1, 0);
    step(1, 0, 8'h70, 1, 8'h04, 8'h20, 1, 0);
    step(1, 0, 8'h89, 1, 8'h05, 8'h00, 0, 0);
    step(1, 0, 8'h1C, 1, 8'h06, 8'h0C, 0, 0);
    step(1, 0, 8'h83, 1, 8'h07, 8'h01, 1, 0);
    step(1, 0, 8'h56, 1, 8'h08, 8'h07, 1, 0);
    step(1, 0, 8'h45, 1, 8'h09, 8'h05, 1, 0);
    step(1, 0, 8'h6F, 1, 8'h0A, 8'h0A, 1, 0);
    step(1, 0, 8'h78, 1, 8'h0B, 8'h00, 0, 0);

    // Stalls, halt, ignored instructions, reset out of halt
    for (int i = 0; i < 3; i++) step(0, 0, 8'h1F, 0, 8'h0B, 8'h00, 0, 0);
    step(1, 0, 8'h15, 1, 8'h0C, 8'h05, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 8'h9F, 0, 8'h0C, 8'h05, 0, 0);
    step(1, 0, 8'hF0, 1, 8'h0C, 8'h05, 0, 1);
    step(1, 0, 8'h1F, 0, 8'h0C, 8'h05, 0, 1);
    step(1, 0, 8'h90, 0, 8'h0C, 8'h05, 0, 1);
    step(0, 1, 8'h1F, 0, 8'h00, 8'h00, 0, 0);

    // PC wrap and reset beating a valid instruction
    for (int i = 1; i <= 254; i++) step(1, 0, 8'h00, 1, 8'(i), 8'h00, 0, 0);
    step(1, 0, 8'h00, 1, 8'hFF, 8'h00, 0, 0);
    step(1, 0, 8'h00, 1, 8'h00, 8'h00, 0, 0);
    step(1, 0, 8'h13, 1, 8'h01, 8'h03, 0, 0);
    step(1, 1, 8'h15, 0, 8'h00, 8'h00, 0, 0);

    ins_valid = 1'b0;
    CLB       = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending entries, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
